// File: rtl/ripple_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ripple_capture_pkg
// Description : Shared types and helpers for the ripple counter capture block.
//               - rcc_state_e : capture FSM encoding
//               - sat_add     : saturating add clamped to a w-bit maximum
//               - sat_ovf     : reports whether that add had to clamp
// Revision    : 1.0 - initial release
// ============================================================================
package ripple_capture_pkg;

    // Helper arithmetic is carried out at this width; operands wider than
    // SAT_ARG_W bits are not supported.
    localparam int SAT_ARG_W = 32;

    typedef enum logic [1:0] {
        S_BASE = 2'd0,
        S_RUN  = 2'd1,
        S_OUT  = 2'd2
    } rcc_state_e;

    // a + b, clamped to 2^w - 1.
    function automatic logic [SAT_ARG_W-1:0] sat_add(
        input logic [SAT_ARG_W-1:0] a,
        input logic [SAT_ARG_W-1:0] b,
        input int unsigned          w
    );
        logic [SAT_ARG_W:0] sum;
        logic [SAT_ARG_W:0] max;
        sum = {1'b0, a} + {1'b0, b};
        max = ({{SAT_ARG_W{1'b0}}, 1'b1} << w) - {{SAT_ARG_W{1'b0}}, 1'b1};
        if (sum > max) begin
            return max[SAT_ARG_W-1:0];
        end
        return sum[SAT_ARG_W-1:0];
    endfunction

    // True when a + b exceeds 2^w - 1, i.e. sat_add had to clamp.
    function automatic logic sat_ovf(
        input logic [SAT_ARG_W-1:0] a,
        input logic [SAT_ARG_W-1:0] b,
        input int unsigned          w
    );
        logic [SAT_ARG_W:0] sum;
        logic [SAT_ARG_W:0] max;
        sum = {1'b0, a} + {1'b0, b};
        max = ({{SAT_ARG_W{1'b0}}, 1'b1} << w) - {{SAT_ARG_W{1'b0}}, 1'b1};
        return (sum > max);
    endfunction

endpackage : ripple_capture_pkg
`default_nettype wire

// File: rtl/ripple_sync_filter.sv
`default_nettype none
// ============================================================================
// Module      : ripple_sync_filter
// Description : Brings the asynchronous ripple counter bus into the clk domain
//               through a SYNC_STAGES-deep flop chain, then waits for the
//               synchronized value to hold for STABLE_CYCLES cycles before
//               accepting it. Multi-bit ripple skew shows up as short-lived
//               intermediate values, which never reach the hold threshold.
// Ports       : clk          - system clock
//               reset        - asynchronous, active-low reset
//               cnt_async    - ripple counter q bus (asynchronous)
//               force_accept - accept a settled value even if unchanged
//               acc          - one-cycle accept pulse
//               acc_value    - the settled value (valid with acc)
//               last_acc     - value of the previous accept
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_sync_filter #(
    parameter int CNT_W         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] cnt_async,
    input  logic             force_accept,
    output logic             acc,
    output logic [CNT_W-1:0] acc_value,
    output logic [CNT_W-1:0] last_acc
);

    localparam int SCW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SCW-1:0] STABLE_MAX = SCW'(STABLE_CYCLES);

    logic [CNT_W-1:0]       sync_q [SYNC_STAGES];
    // Marks which chain stages hold a real sample; reset contents are not
    // trusted as a settled value.
    logic [SYNC_STAGES-1:0] vld_q;
    logic [SCW-1:0]         stable_cnt_q;
    logic [SCW-1:0]         stable_cnt_d;
    logic [CNT_W-1:0]       last_acc_q;

    logic [CNT_W-1:0]       w_synced;
    logic [CNT_W-1:0]       w_next;
    logic                   w_synced_vld;
    logic                   w_next_vld;

    assign w_synced     = sync_q[SYNC_STAGES-1];
    assign w_next       = sync_q[SYNC_STAGES-2];
    assign w_synced_vld = vld_q[SYNC_STAGES-1];
    assign w_next_vld   = vld_q[SYNC_STAGES-2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            vld_q <= '0;
        end else begin
            sync_q[0] <= cnt_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            vld_q <= {vld_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // stable_cnt_q is the number of consecutive cycles the current synced
    // value has been present (1 on its first cycle), saturating at the
    // threshold. It is computed one stage early so acceptance needs no
    // extra pipeline flop.
    always_comb begin
        stable_cnt_d = stable_cnt_q;
        if (!w_next_vld) begin
            stable_cnt_d = '0;
        end else if (w_synced_vld && (w_next == w_synced)) begin
            if (stable_cnt_q != STABLE_MAX) begin
                stable_cnt_d = stable_cnt_q + SCW'(1);
            end
        end else begin
            stable_cnt_d = SCW'(1);
        end
    end

    assign acc = (stable_cnt_q == STABLE_MAX) &&
                 (force_accept || (w_synced != last_acc_q));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_cnt_q <= '0;
            last_acc_q   <= '0;
        end else begin
            stable_cnt_q <= stable_cnt_d;
            if (acc) begin
                last_acc_q <= w_synced;
            end
        end
    end

    assign acc_value = w_synced;
    assign last_acc  = last_acc_q;

endmodule : ripple_sync_filter
`default_nettype wire

// File: rtl/ripple_count_capture.sv
`default_nettype none
// ============================================================================
// Module      : ripple_count_capture
// Description : Consumer of a ripple carry counter. Each settled count change
//               becomes a modulo delta offered on a valid/ready port, and a
//               saturating running total of events is kept.
//               Optional feature macro RIPPLE_CAPTURE_ALIAS_WARN_EN adds the
//               alias_warn output (pulse when a delta is >= half the counter
//               range, i.e. the counter may have wrapped unseen).
// Ports       : clk         - system clock
//               reset       - asynchronous, active-low reset
//               cnt_async   - ripple counter q bus (asynchronous)
//               clear       - synchronous clear / re-baseline
//               baselined   - first settled value captured
//               delta_valid - delta available
//               delta_ready - consumer accepts delta
//               delta       - events since previous handshaken delta
//               total       - saturating event total
//               total_sat   - sticky saturation flag
//               alias_warn  - (optional) possible-aliasing pulse
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_count_capture
    import ripple_capture_pkg::*;
#(
    parameter int CNT_W         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2,
    parameter int ACC_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] cnt_async,
    input  logic             clear,
    output logic             baselined,
    output logic             delta_valid,
    input  logic             delta_ready,
    output logic [ACC_W-1:0] delta,
    output logic [ACC_W-1:0] total,
    output logic             total_sat
`ifdef RIPPLE_CAPTURE_ALIAS_WARN_EN
    ,
    output logic             alias_warn
`endif
);

    rcc_state_e       state_q, state_d;
    logic             baselined_q, baselined_d;
    logic [ACC_W-1:0] delta_q, delta_d;
    logic [ACC_W-1:0] pend_q, pend_d;
    logic [ACC_W-1:0] total_q, total_d;
    logic             total_sat_q, total_sat_d;

    logic             w_acc;
    logic [CNT_W-1:0] w_acc_value;
    logic [CNT_W-1:0] w_last_acc;
    logic [CNT_W-1:0] w_dcnt;
    logic [ACC_W-1:0] w_d;
    logic [ACC_W-1:0] w_d_acc;

    ripple_sync_filter #(
        .CNT_W         (CNT_W),
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk          (clk),
        .reset        (reset),
        .cnt_async    (cnt_async),
        .force_accept (state_q == S_BASE),
        .acc          (w_acc),
        .acc_value    (w_acc_value),
        .last_acc     (w_last_acc)
    );

    // Modulo difference in counter width; wraps naturally.
    assign w_dcnt  = w_acc_value - w_last_acc;
    assign w_d     = ACC_W'(w_dcnt);
    assign w_d_acc = w_acc ? w_d : '0;

    always_comb begin
        state_d     = state_q;
        baselined_d = baselined_q;
        delta_d     = delta_q;
        pend_d      = pend_q;
        total_d     = total_q;
        total_sat_d = total_sat_q;

        if (clear) begin
            state_d     = S_BASE;
            baselined_d = 1'b0;
            delta_d     = '0;
            pend_d      = '0;
            total_d     = '0;
            total_sat_d = 1'b0;
        end else begin
            // The total tracks accepts directly, independent of the consumer.
            if (w_acc && (state_q != S_BASE)) begin
                total_d = ACC_W'(sat_add(SAT_ARG_W'(total_q), SAT_ARG_W'(w_d), ACC_W));
                if (sat_ovf(SAT_ARG_W'(total_q), SAT_ARG_W'(w_d), ACC_W)) begin
                    total_sat_d = 1'b1;
                end
            end

            case (state_q)
                S_BASE: begin
                    if (w_acc) begin
                        baselined_d = 1'b1;
                        state_d     = S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_acc) begin
                        delta_d = w_d;
                        state_d = S_OUT;
                    end
                end
                S_OUT: begin
                    if (delta_ready) begin
                        // Events that arrived while stalled, plus any accept
                        // landing on the handshake cycle, form the next delta.
                        if ((pend_q != '0) || w_acc) begin
                            delta_d = ACC_W'(sat_add(SAT_ARG_W'(pend_q), SAT_ARG_W'(w_d_acc), ACC_W));
                            pend_d  = '0;
                        end else begin
                            state_d = S_RUN;
                        end
                    end else if (w_acc) begin
                        pend_d = ACC_W'(sat_add(SAT_ARG_W'(pend_q), SAT_ARG_W'(w_d), ACC_W));
                    end
                end
                default: begin
                    state_d = S_BASE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_BASE;
            baselined_q <= 1'b0;
            delta_q     <= '0;
            pend_q      <= '0;
            total_q     <= '0;
            total_sat_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            baselined_q <= baselined_d;
            delta_q     <= delta_d;
            pend_q      <= pend_d;
            total_q     <= total_d;
            total_sat_q <= total_sat_d;
        end
    end

    assign baselined   = baselined_q;
    assign delta_valid = (state_q == S_OUT);
    assign delta       = delta_q;
    assign total       = total_q;
    assign total_sat   = total_sat_q;

`ifdef RIPPLE_CAPTURE_ALIAS_WARN_EN
    logic alias_warn_q;

    // A delta in the upper half of the counter range may be a wrap of a
    // larger count that the capture cannot distinguish.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alias_warn_q <= 1'b0;
        end else begin
            alias_warn_q <= !clear && w_acc && (state_q != S_BASE) && w_dcnt[CNT_W-1];
        end
    end

    assign alias_warn = alias_warn_q;
`endif

endmodule : ripple_count_capture
`default_nettype wire
